// File: rtl/dla_reset_sequencer.sv
// dla_reset_sequencer
//   Ordered reset-release controller for the DLA downstream domains.
//   All stage resets are held for HOLD_CYCLES. Stages are then released one
//   at a time, lowest index first. Each later stage is released GAP_CYCLES
//   after the previous stage acknowledges. A stage that never acknowledges
//   is forced through after TIMEOUT_CYCLES, and o_timeout_err is set.
//   A soft reset request restarts the whole sequence.
// Ports
//   clk             sole clock
//   i_async_reset   async active-high reset (deassertion pre-synchronized)
//   i_sw_reset_req  soft-reset request, level-sampled
//   i_stage_ack     per-stage out-of-reset acknowledge (clk domain)
//   o_stage_resetn  active-low per-stage reset, registered
//   o_busy          sequence in progress
//   o_done          all stages released
//   o_timeout_err   sticky: a stage timed out in the current sequence
module dla_reset_sequencer #(
  parameter int NUM_STAGES     = 4,
  parameter int HOLD_CYCLES    = 16,
  parameter int GAP_CYCLES     = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  i_async_reset,
  input  logic                  i_sw_reset_req,
  input  logic [NUM_STAGES-1:0] i_stage_ack,
  output logic [NUM_STAGES-1:0] o_stage_resetn,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_timeout_err
);

  localparam int MAXC = (HOLD_CYCLES > GAP_CYCLES) ?
                        ((HOLD_CYCLES > TIMEOUT_CYCLES) ? HOLD_CYCLES : TIMEOUT_CYCLES) :
                        ((GAP_CYCLES  > TIMEOUT_CYCLES) ? GAP_CYCLES  : TIMEOUT_CYCLES);
  localparam int CW = $clog2(MAXC) + 1;
  localparam int IW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] TMO_LAST  = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_STAGES - 1);

  typedef enum logic [1:0] {S_HOLD, S_WAIT_ACK, S_GAP, S_DONE} state_t;

  state_t                r_state, w_state_nxt;
  logic [CW-1:0]         r_cnt,   w_cnt_nxt;
  logic [IW-1:0]         r_idx,   w_idx_nxt;
  logic [NUM_STAGES-1:0] r_rstn,  w_rstn_nxt;
  logic                  r_busy,  w_busy_nxt;
  logic                  r_done,  w_done_nxt;
  logic                  r_err,   w_err_nxt;
  logic                  w_ack;
  logic                  w_release;  // release stage w_idx_nxt on this edge
  logic                  w_tmo;      // current stage forced through by timeout
  logic                  w_finish;   // last stage completed on this edge

  // Only the stage being served is looked at.
  assign w_ack = i_stage_ack[r_idx];

  // State register
  always_ff @(posedge clk or posedge i_async_reset) begin
    if (i_async_reset) begin
      r_state <= S_HOLD;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_rstn  <= '0;
      r_busy  <= 1'b1;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_rstn  <= w_rstn_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_release   = 1'b0;
    w_tmo       = 1'b0;
    w_finish    = 1'b0;
    if (i_sw_reset_req) begin
      // Held request pins the block in HOLD with cnt=0.
      w_state_nxt = S_HOLD;
      w_cnt_nxt   = '0;
      w_idx_nxt   = '0;
    end else begin
      case (r_state)
        S_HOLD: begin
          if (r_cnt == HOLD_LAST) begin
            w_state_nxt = S_WAIT_ACK;
            w_cnt_nxt   = '0;
            w_release   = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
        S_WAIT_ACK: begin
          // Ack beats a coincident timeout, so no error in that case.
          if (w_ack || (r_cnt == TMO_LAST)) begin
            w_tmo     = !w_ack;
            w_cnt_nxt = '0;
            if (r_idx == IDX_LAST) begin
              w_state_nxt = S_DONE;
              w_finish    = 1'b1;
            end else begin
              w_state_nxt = S_GAP;
            end
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
        S_GAP: begin
          if (r_cnt == GAP_LAST) begin
            w_state_nxt = S_WAIT_ACK;
            w_cnt_nxt   = '0;
            w_idx_nxt   = r_idx + IW'(1);
            w_release   = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
        default: ;  // S_DONE holds
      endcase
    end
  end

  // Output logic: next values of the registered outputs
  always_comb begin
    w_rstn_nxt = r_rstn;
    w_busy_nxt = r_busy;
    w_done_nxt = r_done;
    w_err_nxt  = r_err;
    if (i_sw_reset_req) begin
      w_rstn_nxt = '0;
      w_busy_nxt = 1'b1;
      w_done_nxt = 1'b0;
      w_err_nxt  = 1'b0;
    end else begin
      if (w_release) w_rstn_nxt[w_idx_nxt] = 1'b1;
      if (w_tmo)     w_err_nxt = 1'b1;
      if (w_finish) begin
        w_done_nxt = 1'b1;
        w_busy_nxt = 1'b0;
      end
    end
  end

  assign o_stage_resetn = r_rstn;
  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_timeout_err  = r_err;

endmodule
